rs_encode_stream_in_ctrl: RTL
=============================

// Module: rs_encode_stream_in_ctrl
// PURPOSE
// Control FSM for the RS encoder stream-input datapath. Accepts a request header,
// hands its metadata to the output side, then moves NUM_DATA_LINES source lines per
// RS block into the line encoder, followed by one zero pad line, for every block.
// Drives the datapath count/store strobes. Consumes its last-line/last-block flags.
// PARAMETERS
// NUM_REQ_BLOCKS    8                            max blocks per request
// NUM_REQ_BLOCKS_W  $clog2(NUM_REQ_BLOCKS)       block-count index width (count port is W+1)
// PORTS
// clk                               in   1     clock
// rst_n                             in   1     async active-low reset
// src_stream_encoder_req_val        in   1     request header valid
// src_stream_encoder_req_num_blocks in   W+1   blocks in request (zero check only)
// stream_encoder_src_req_rdy        out  1     request header accepted
// src_stream_encoder_req_data_val   in   1     source data line valid
// stream_encoder_src_req_data_rdy   out  1     source data line consumed
// stream_encode_line_val            out  1     line to encoder valid (data or pad)
// stream_encode_line_last           out  1     current line is the block pad line
// encode_line_stream_encode_rdy     in   1     encoder accepts line
// in_ctrl_out_ctrl_req_val          out  1     metadata valid to output side
// out_ctrl_in_ctrl_req_rdy          in   1     output side accepts metadata
// in_ctrl_in_datap_store_req_meta   out  1     datapath: latch num_blocks
// in_ctrl_in_datap_init_line_count  out  1     datapath: line count <= 0
// in_ctrl_in_datap_incr_line_count  out  1     datapath: line count += 1
// in_ctrl_in_datap_init_block_count out  1     datapath: block count <= 0
// in_ctrl_in_datap_incr_block_count out  1     datapath: block count += 1
// in_datap_in_ctrl_last_data_line   in   1     line count == NUM_DATA_LINES-1
// in_datap_in_ctrl_last_block       in   1     block count == num_blocks-1
// BEHAVIOUR
// - Reset: state=IDLE. All outputs are 0 while rst_n=0. Deassertion takes effect at the next clk.
// - All outputs are Moore/Mealy combinational from state and inputs. No output registers.
// - IDLE: req_rdy=1. On req_val: store_req_meta=1, init_line=1, init_block=1, then go to META.
// - META: out req_val=1. On out rdy: go to IDLE if the latched request had num_blocks==0,
//   else go to DATA. The zero flag is captured in IDLE alongside store_req_meta.
// - DATA: line_val=src data_val and data_rdy=encoder rdy, both pass-through.
//   - Handshake is line_val&&rdy. On handshake: incr_line=1.
//   - If last_data_line is also set on that handshake, go to PAD.
// - PAD: line_val=1, line_last=1, data_rdy=0. Datapath emits zeros because pad_sel is set.
//   - On encoder rdy: incr_line=1 (count reaches NUM_LINES-1 only during PAD, then resets).
//   - On encoder rdy: init_line=1 takes priority, so the line count goes to 0.
//   - If last_block: go to IDLE. Else incr_block=1 and go to DATA.
// - init strobes take priority over incr strobes in the datapath. The FSM never asserts
//   init and incr of the same counter in the same cycle except in PAD, where init wins.
// - req_rdy is 0 outside IDLE. A new header is never accepted mid-request.
// - Data valid while in IDLE/META/PAD is held off (data_rdy=0) and not dropped.
// - Encoder backpressure in PAD holds line_val=1. No strobe fires until rdy.
// - rst_n asserted mid-request: immediate return to IDLE. The partial request is abandoned
//   and the datapath counters are re-initialised by the next header.
// - Throughput: 1 line/cycle in DATA. 1 bubble-free pad cycle per block. 2 cycles of header overhead.
// TESTING
// - Reset, then header num_blocks=1, NUM_DATA_LINES=4, all rdy=1 -> IDLE,META,4xDATA,PAD,IDLE.
//   Expect 5 encoder lines, the 5th with last=1 and zero data.
// - num_blocks=3, continuous data -> 15 encoder lines, incr_block pulses at pads 1,2 only,
//   req_rdy reasserts after the 3rd pad.
// - num_blocks=0 -> store_meta pulse, out req handshake, return to IDLE.
//   No line_val and no data_rdy.
// - Encoder rdy toggled 1010 during DATA and PAD -> data_rdy mirrors rdy, incr_line only on
//   rdy cycles, pad line held until accepted.
// - out_ctrl rdy held 0 for 5 cycles -> FSM stays in META, req_rdy=0, data_rdy=0 throughout.
// - rst_n pulsed low after 2 of 4 lines of block 0 -> outputs 0 immediately.
//   A fresh header of num_blocks=1 completes normally.

Source files
------------

// File: rtl/rs_encode_stream_in_ctrl.sv
// Input-side control FSM of the RS encoder stream path: accepts a request header, hands
// its metadata to the output side, then feeds data lines plus one zero pad line per block.
module rs_encode_stream_in_ctrl #(
   parameter int NUM_REQ_BLOCKS   = 8,
   parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS)
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic                        src_stream_encoder_req_val,
   input  logic [NUM_REQ_BLOCKS_W:0]   src_stream_encoder_req_num_blocks,
   output logic                        stream_encoder_src_req_rdy,

   input  logic                        src_stream_encoder_req_data_val,
   output logic                        stream_encoder_src_req_data_rdy,

   output logic                        stream_encode_line_val,
   output logic                        stream_encode_line_last,
   input  logic                        encode_line_stream_encode_rdy,

   output logic                        in_ctrl_out_ctrl_req_val,
   input  logic                        out_ctrl_in_ctrl_req_rdy,

   output logic                        in_ctrl_in_datap_store_req_meta,
   output logic                        in_ctrl_in_datap_init_line_count,
   output logic                        in_ctrl_in_datap_incr_line_count,
   output logic                        in_ctrl_in_datap_init_block_count,
   output logic                        in_ctrl_in_datap_incr_block_count,

   input  logic                        in_datap_in_ctrl_last_data_line,
   input  logic                        in_datap_in_ctrl_last_block,

   output logic [1:0]                  in_ctrl_state_dbg
);

   // Handshakes: a transfer happens on a cycle where both val and rdy are high at the
   // rising clk edge; val never depends on rdy, and val stays up until the transfer.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_META = 2'd1,
      ST_DATA = 2'd2,
      ST_PAD  = 2'd3
   } state_e;

   state_e state_r;
   state_e state_nxt;
   logic   zero_blocks_r;
   logic   zero_blocks_nxt;

   logic   req_rdy_raw;
   logic   data_rdy_raw;
   logic   line_val_raw;
   logic   line_last_raw;
   logic   out_req_val_raw;
   logic   store_meta_raw;
   logic   init_line_raw;
   logic   incr_line_raw;
   logic   init_block_raw;
   logic   incr_block_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         zero_blocks_r <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         zero_blocks_r <= zero_blocks_nxt;
      end
   end

   always_comb begin
      state_nxt       = state_r;
      zero_blocks_nxt = zero_blocks_r;
      req_rdy_raw     = 1'b0;
      data_rdy_raw    = 1'b0;
      line_val_raw    = 1'b0;
      line_last_raw   = 1'b0;
      out_req_val_raw = 1'b0;
      store_meta_raw  = 1'b0;
      init_line_raw   = 1'b0;
      incr_line_raw   = 1'b0;
      init_block_raw  = 1'b0;
      incr_block_raw  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            req_rdy_raw = 1'b1;
            if (src_stream_encoder_req_val) begin
               store_meta_raw  = 1'b1;
               init_line_raw   = 1'b1;
               init_block_raw  = 1'b1;
               zero_blocks_nxt = (src_stream_encoder_req_num_blocks == '0);
               state_nxt       = ST_META;
            end
         end

         ST_META: begin
            out_req_val_raw = 1'b1;
            if (out_ctrl_in_ctrl_req_rdy) begin
               state_nxt = zero_blocks_r ? ST_IDLE : ST_DATA;
            end
         end

         ST_DATA: begin
            line_val_raw = src_stream_encoder_req_data_val;
            data_rdy_raw = encode_line_stream_encode_rdy;
            if (src_stream_encoder_req_data_val && encode_line_stream_encode_rdy) begin
               incr_line_raw = 1'b1;
               if (in_datap_in_ctrl_last_data_line) begin
                  state_nxt = ST_PAD;
               end
            end
         end

         ST_PAD: begin
            line_val_raw  = 1'b1;
            line_last_raw = 1'b1;
            // Both line strobes fire on the pad handshake; the datapath lets init win.
            if (encode_line_stream_encode_rdy) begin
               incr_line_raw = 1'b1;
               init_line_raw = 1'b1;
               if (in_datap_in_ctrl_last_block) begin
                  state_nxt = ST_IDLE;
               end else begin
                  incr_block_raw = 1'b1;
                  state_nxt      = ST_DATA;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are forced low combinationally so they drop the moment rst_n falls.
   always_comb begin
      stream_encoder_src_req_rdy        = req_rdy_raw     & rst_n;
      stream_encoder_src_req_data_rdy   = data_rdy_raw    & rst_n;
      stream_encode_line_val            = line_val_raw    & rst_n;
      stream_encode_line_last           = line_last_raw   & rst_n;
      in_ctrl_out_ctrl_req_val          = out_req_val_raw & rst_n;
      in_ctrl_in_datap_store_req_meta   = store_meta_raw  & rst_n;
      in_ctrl_in_datap_init_line_count  = init_line_raw   & rst_n;
      in_ctrl_in_datap_incr_line_count  = incr_line_raw   & rst_n;
      in_ctrl_in_datap_init_block_count = init_block_raw  & rst_n;
      in_ctrl_in_datap_incr_block_count = incr_block_raw  & rst_n;
   end

   assign in_ctrl_state_dbg = state_r;

endmodule
